shift_seq: RTL and testbench

Iterative shift controller that sits directly upstream of `ari_shift`, the 8-bit combinational shift/rotate stage. It accepts an 8-bit operand and a 3-bit shift amount (0–7) through a start/busy/done handshake. It drives the 0–3-bit shifter repeatedly in steps of at most 3 and captures each intermediate result. It returns the final value to the datapath, extending the shifter's reach from 3 bits to 7 bits without adding gates to the shifter.

---
 rtl/shift_seq_pkg.sv | 12 +
 rtl/shift_seq_if.sv | 31 +++
 rtl/shift_seq_step_dec.sv | 19 +
 rtl/shift_seq.sv | 90 +++++++++
 tb/tb_shift_seq.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the iterative shift controller that feeds the
// 0-3 bit combinational shifter.
package shift_seq_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} shift_state_t;

    localparam int SH_W         = 8;
    localparam int STEP_MAX     = 3;
    // Gate delay of the shifter family; sets the step-decode timing budget.
    localparam int NAND_TIME_NS = 7;

endpackage

// File: rtl/shift_seq_if.sv
// Request handshake plus the shifter-side bus of shift_seq. The master is the
// parent datapath (requester and shifter owner); the slave is shift_seq itself.
interface shift_seq_if;
    import shift_seq_pkg::*;

    logic            start;
    logic [SH_W-1:0] op_a;
    logic            left;
    logic            rotate;
    logic [2:0]      amt;
    logic            busy;
    logic            done;
    logic [SH_W-1:0] result;

    logic [SH_W-1:0] sh_a;
    logic            sh_left;
    logic            sh_rotate;
    logic [1:0]      sh_amt;
    logic [SH_W-1:0] sh_c;

    modport master (
        output start, op_a, left, rotate, amt, sh_c,
        input  busy, done, result, sh_a, sh_left, sh_rotate, sh_amt
    );

    modport slave (
        input  start, op_a, left, rotate, amt, sh_c,
        output busy, done, result, sh_a, sh_left, sh_rotate, sh_amt
    );

endinterface

// File: rtl/shift_seq_step_dec.sv
// Step decode min(rem,3) written as two-level NAND logic so it matches the
// shifter's gate style: step[1] = rem[2]|rem[1], step[0] = rem[2]|rem[0].
module shift_step_dec (
    input  logic [2:0] rem,
    output logic [1:0] step
);

    logic [2:0] rem_n;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_inv
            assign rem_n[gi] = ~(rem[gi] & rem[gi]);
        end
    endgenerate

    assign step[1] = ~(rem_n[2] & rem_n[1]);
    assign step[0] = ~(rem_n[2] & rem_n[0]);

endmodule

// File: rtl/shift_seq.sv
// Iterative shift controller: splits a 0-7 bit shift/rotate into steps of at
// most 3 on the external shifter and captures each intermediate result.
module shift_seq
    import shift_seq_pkg::*;
(
    input  logic        clk,
    input  logic        reset_,
    shift_seq_if.slave  bus
);

    shift_state_t    state_reg, state_next;
    logic [SH_W-1:0] acc_reg, acc_next;
    logic [SH_W-1:0] result_reg, result_next;
    logic [2:0]      rem_reg, rem_next;
    logic            left_reg, left_next;
    logic            rotate_reg, rotate_next;
    logic [1:0]      step;
    logic [2:0]      rem_after;

    shift_step_dec u_step_dec (
        .rem  (rem_reg),
        .step (step)
    );

    // step never exceeds rem, so this cannot wrap
    assign rem_after = rem_reg - {1'b0, step};

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_reg  <= IDLE;
            acc_reg    <= '0;
            result_reg <= '0;
            rem_reg    <= '0;
            left_reg   <= 1'b0;
            rotate_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            acc_reg    <= acc_next;
            result_reg <= result_next;
            rem_reg    <= rem_next;
            left_reg   <= left_next;
            rotate_reg <= rotate_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        acc_next    = acc_reg;
        result_next = result_reg;
        rem_next    = rem_reg;
        left_next   = left_reg;
        rotate_next = rotate_reg;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    acc_next    = bus.op_a;
                    left_next   = bus.left;
                    rotate_next = bus.rotate;
                    rem_next    = bus.amt;
                    if (bus.amt == 3'd0) begin
                        result_next = bus.op_a;
                        state_next  = DONE;
                    end else begin
                        state_next  = SHIFT;
                    end
                end
            end
            SHIFT: begin
                acc_next = bus.sh_c;
                rem_next = rem_after;
                if (rem_after == 3'd0) begin
                    result_next = bus.sh_c;
                    state_next  = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outside SHIFT the shifter sees amount 0 and simply passes the accumulator
    assign bus.sh_amt    = (state_reg == SHIFT) ? step : 2'd0;
    assign bus.sh_a      = acc_reg;
    assign bus.sh_left   = left_reg;
    assign bus.sh_rotate = rotate_reg;
    assign bus.busy      = (state_reg != IDLE);
    assign bus.done      = (state_reg == DONE);
    assign bus.result    = result_reg;

endmodule

// File: tb/tb_shift_seq.sv
// Self-checking bench for shift_seq: behavioural shifter, per-operation
// expected-cycle schedule, directed cases with literal results, random traffic.
module tb_shift_seq;

    logic clk = 1'b0;
    logic reset_ = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    shift_seq_if ifc ();

    shift_seq dut (
        .clk    (clk),
        .reset_ (reset_),
        .bus    (ifc)
    );

    initial forever #5 clk = ~clk;

    // Shift/rotate of an 8-bit value by n positions (any n 0..7)
    function automatic logic [7:0] shf(input logic [7:0] v, input logic l, input logic r, input int n);
        logic [15:0] d;
        d = {v, v};
        if (r) begin
            if (l) begin
                d = d << n;
                return d[15:8];
            end
            d = d >> n;
            return d[7:0];
        end
        if (l) return 8'(v << n);
        return 8'($signed(v) >>> n);
    endfunction

    assign ifc.sh_c = shf(ifc.sh_a, ifc.sh_left, ifc.sh_rotate, int'(ifc.sh_amt));

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected output per cycle while an operation is in flight
    typedef struct {
        logic       busy;
        logic       done;
        logic [1:0] amt;
        logic [7:0] sha;
        logic [7:0] res;
    } exp_t;

    exp_t       q[$];
    logic [7:0] m_res = 8'h00;
    logic [7:0] m_acc = 8'h00;
    logic       m_left = 1'b0;
    logic       m_rot = 1'b0;

    always @(posedge clk or negedge reset_) begin : model
        exp_t e;
        logic [7:0] v;
        int r;
        int s;
        if (!reset_) begin
            q.delete();
            m_res  = 8'h00;
            m_acc  = 8'h00;
            m_left = 1'b0;
            m_rot  = 1'b0;
        end else if (q.size() != 0) begin
            e = q.pop_front();
            if (e.done) begin
                m_res = e.res;
                m_acc = e.sha;
            end
        end else if (ifc.start) begin
            m_left = ifc.left;
            m_rot  = ifc.rotate;
            v = ifc.op_a;
            r = int'(ifc.amt);
            while (r > 0) begin
                s = (r > 3) ? 3 : r;
                q.push_back('{busy: 1'b1, done: 1'b0, amt: 2'(s), sha: v, res: m_res});
                v = shf(v, m_left, m_rot, s);
                r -= s;
            end
            q.push_back('{busy: 1'b1, done: 1'b1, amt: 2'd0, sha: v,
                          res: shf(ifc.op_a, m_left, m_rot, int'(ifc.amt))});
        end
    end

    always @(negedge clk) begin : compare
        exp_t e;
        if (q.size() != 0) e = q[0];
        else e = '{busy: 1'b0, done: 1'b0, amt: 2'd0, sha: m_acc, res: m_res};
        chk("busy",      {7'd0, ifc.busy},      {7'd0, e.busy});
        chk("done",      {7'd0, ifc.done},      {7'd0, e.done});
        chk("sh_amt",    {6'd0, ifc.sh_amt},    {6'd0, e.amt});
        chk("sh_a",      ifc.sh_a,              e.sha);
        chk("result",    ifc.result,            e.res);
        chk("sh_left",   {7'd0, ifc.sh_left},   {7'd0, m_left});
        chk("sh_rotate", {7'd0, ifc.sh_rotate}, {7'd0, m_rot});
    end

    task automatic run_op(input logic [7:0] op, input logic l, input logic r, input logic [2:0] a,
                          input logic [7:0] exp_res, input int exp_lat);
        int lat;
        @(posedge clk); #1;
        ifc.start = 1'b1; ifc.op_a = op; ifc.left = l; ifc.rotate = r; ifc.amt = a;
        @(posedge clk); #1;
        ifc.start = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!ifc.done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("op_done_seen", {7'd0, ifc.done}, 8'd1);
        chk("op_latency", 8'(lat), 8'(exp_lat));
        chk("op_result", ifc.result, exp_res);
        @(posedge clk); #1;
    endtask

    initial begin : stim
        int ndone;
        ifc.start = 1'b0; ifc.op_a = 8'h00; ifc.left = 1'b0; ifc.rotate = 1'b0; ifc.amt = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {7'd0, ifc.busy}, 8'd0);
        chk("rst_result", ifc.result, 8'h00);
        reset_ = 1'b1;

        run_op(8'h80, 1'b0, 1'b0, 3'd7, 8'hFF, 4);
        run_op(8'h81, 1'b1, 1'b0, 3'd5, 8'h20, 3);
        run_op(8'h01, 1'b0, 1'b1, 3'd7, 8'h02, 4);
        run_op(8'h81, 1'b1, 1'b1, 3'd4, 8'h18, 3);
        run_op(8'h5A, 1'b0, 1'b0, 3'd0, 8'h5A, 1);
        run_op(8'hC3, 1'b1, 1'b1, 3'd2, 8'h0F, 2);

        // starts during busy (including the DONE cycle) must be ignored
        @(posedge clk); #1;
        ifc.start = 1'b1; ifc.op_a = 8'h40; ifc.left = 1'b0; ifc.rotate = 1'b0; ifc.amt = 3'd6;
        @(posedge clk); #1;
        ifc.op_a = 8'hFF; ifc.amt = 3'd7; ifc.left = 1'b1;
        ndone = 0;
        repeat (3) begin
            @(negedge clk);
            if (ifc.done) ndone++;
            @(posedge clk); #1;
        end
        ifc.start = 1'b0;
        chk("busy_ign_ndone", 8'(ndone), 8'd1);
        chk("busy_ign_result", ifc.result, 8'h01);
        chk("busy_ign_idle", {7'd0, ifc.busy}, 8'd0);

        // reset in the second SHIFT cycle aborts at once
        @(posedge clk); #1;
        ifc.start = 1'b1; ifc.op_a = 8'h80; ifc.left = 1'b0; ifc.rotate = 1'b0; ifc.amt = 3'd7;
        @(posedge clk); #1;
        ifc.start = 1'b0;
        @(posedge clk); #2;
        reset_ = 1'b0;
        #1;
        chk("abort_busy", {7'd0, ifc.busy}, 8'd0);
        chk("abort_done", {7'd0, ifc.done}, 8'd0);
        chk("abort_result", ifc.result, 8'h00);
        chk("abort_sh_amt", {6'd0, ifc.sh_amt}, 8'd0);
        @(posedge clk); #1;
        reset_ = 1'b1;
        run_op(8'h40, 1'b0, 1'b0, 3'd6, 8'h01, 3);

        // random traffic, with starts while busy and occasional aborts
        repeat (4000) begin
            @(posedge clk); #1;
            ifc.start  = ($urandom_range(0, 2) == 0);
            ifc.op_a   = 8'($urandom);
            ifc.left   = 1'($urandom);
            ifc.rotate = 1'($urandom);
            ifc.amt    = 3'($urandom);
            if ($urandom_range(0, 299) == 0) begin
                #1;
                reset_ = 1'b0;
                @(posedge clk); #1;
                reset_ = 1'b1;
            end
        end
        ifc.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("final_idle", {7'd0, ifc.busy}, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
